// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the program counter, presents the fetch
// address to the combinational instruction ROM, and registers the returned
// word into the IF/ID pipeline register. Handles hazard stalls and
// branch/jump redirects resolved in ID, and counts accepted fetches.
module if_fetch_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic [31:0] pc,
    input  logic [31:0] inst_in,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_inst,
    output logic        if_id_valid,
    output logic [31:0] fetch_count
);

    // Clear the byte offset so every fetch address is word aligned.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    logic [31:0] pc_q,          pc_d;
    logic [31:0] if_id_pc_q,    if_id_pc_d;
    logic [31:0] if_id_pc4_q,   if_id_pc4_d;
    logic [31:0] if_id_inst_q,  if_id_inst_d;
    logic        if_id_valid_q, if_id_valid_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic        redirect_s;
    logic [31:0] redirect_pc_s;
    logic [31:0] pc_plus4_s;

    // Branch has priority over jump when both are raised in the same cycle.
    always_comb begin
        redirect_s    = branch_taken | jump;
        redirect_pc_s = 32'h0000_0000;
        if (branch_taken) begin
            redirect_pc_s = align_word(branch_target);
        end else if (jump) begin
            redirect_pc_s = align_word(jump_target);
        end else begin
            redirect_pc_s = 32'h0000_0000;
        end
        pc_plus4_s = pc_q + 32'd4;
    end

    // Next-state for PC and IF/ID: redirect beats stall, stall beats advance.
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        fetch_count_d = fetch_count_q;
        if (redirect_s) begin
            // The word fetched this cycle is wrong-path: squash it.
            pc_d          = redirect_pc_s;
            if_id_pc_d    = 32'h0000_0000;
            if_id_pc4_d   = 32'h0000_0000;
            if_id_inst_d  = 32'h0000_0000;
            if_id_valid_d = 1'b0;
        end else if (stall) begin
            pc_d          = pc_q;
            if_id_pc_d    = if_id_pc_q;
            if_id_pc4_d   = if_id_pc4_q;
            if_id_inst_d  = if_id_inst_q;
            if_id_valid_d = if_id_valid_q;
        end else begin
            pc_d          = pc_plus4_s;
            if_id_pc_d    = pc_q;
            if_id_pc4_d   = pc_plus4_s;
            if_id_inst_d  = inst_in;
            if_id_valid_d = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    // State registers; reset drops everything without waiting for a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= PC_RESET;
            if_id_pc_q    <= 32'h0000_0000;
            if_id_pc4_q   <= 32'h0000_0000;
            if_id_inst_q  <= 32'h0000_0000;
            if_id_valid_q <= 1'b0;
            fetch_count_q <= 32'h0000_0000;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign pc          = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_pc4   = if_id_pc4_q;
    assign if_id_inst  = if_id_inst_q;
    assign if_id_valid = if_id_valid_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: a 64-word ROM model feeds inst_in, a reference
// model predicts the post-edge state when stimulus is driven and pushes it to
// a scoreboard queue that is popped and compared after each rising edge.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc;
    logic [31:0] inst_in;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_inst;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int checks_cnt = 0;
    int errors_cnt = 0;

    logic [31:0] rom [0:63];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] ipc4;
        logic [31:0] inst;
        logic        valid;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mdl;

    if_fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc            (pc),
        .inst_in       (inst_in),
        .if_id_pc      (if_id_pc),
        .if_id_pc4     (if_id_pc4),
        .if_id_inst    (if_id_inst),
        .if_id_valid   (if_id_valid),
        .fetch_count   (fetch_count)
    );

    // Combinational ROM decoding only pc[7:2].
    assign inst_in = rom[pc[7:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl.pc    = 32'h0000_0000;
        mdl.ipc   = 32'h0000_0000;
        mdl.ipc4  = 32'h0000_0000;
        mdl.inst  = 32'h0000_0000;
        mdl.valid = 1'b0;
        mdl.cnt   = 32'h0000_0000;
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_pc"},    pc,                 32'h0000_0000);
        check_val({tag, "_ipc"},   if_id_pc,           32'h0000_0000);
        check_val({tag, "_ipc4"},  if_id_pc4,          32'h0000_0000);
        check_val({tag, "_inst"},  if_id_inst,         32'h0000_0000);
        check_val({tag, "_valid"}, {31'd0, if_id_valid}, 32'h0000_0000);
        check_val({tag, "_cnt"},   fetch_count,        32'h0000_0000);
    endtask

    // Drive one cycle of stimulus, predict, clock, then compare against the scoreboard.
    task automatic step(input logic st, input logic bt, input logic [31:0] btgt,
                        input logic jp, input logic [31:0] jtgt);
        exp_t nx;
        exp_t got;
        stall         = st;
        branch_taken  = bt;
        branch_target = btgt;
        jump          = jp;
        jump_target   = jtgt;
        nx = mdl;
        if (bt) begin
            nx.pc = btgt & 32'hFFFF_FFFC;
            nx.ipc = 32'h0; nx.ipc4 = 32'h0; nx.inst = 32'h0; nx.valid = 1'b0;
        end else if (jp) begin
            nx.pc = jtgt & 32'hFFFF_FFFC;
            nx.ipc = 32'h0; nx.ipc4 = 32'h0; nx.inst = 32'h0; nx.valid = 1'b0;
        end else if (!st) begin
            nx.ipc   = mdl.pc;
            nx.ipc4  = mdl.pc + 32'd4;
            nx.inst  = rom[mdl.pc[7:2]];
            nx.valid = 1'b1;
            nx.pc    = mdl.pc + 32'd4;
            nx.cnt   = mdl.cnt + 32'd1;
        end
        sb_q.push_back(nx);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_val("sb_pc",    pc,          got.pc);
            check_val("sb_ipc",   if_id_pc,    got.ipc);
            check_val("sb_ipc4",  if_id_pc4,   got.ipc4);
            check_val("sb_inst",  if_id_inst,  got.inst);
            check_val("sb_valid", {31'd0, if_id_valid}, {31'd0, got.valid});
            check_val("sb_cnt",   fetch_count, got.cnt);
            mdl = got;
        end
    endtask

    task automatic free_step();
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            rom[i] = 32'hA500_0000 | 32'(i);
        end
        rom[0] = 32'h0000_0000;
        rom[1] = 32'h1400_0801;
        rom[2] = 32'h1400_0022;
        rom[3] = 32'h0010_0c41;
        rom[6] = 32'h0010_0c80;

        rst_n = 1'b0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;
        model_reset();
        #2;
        check_reset_vals("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Free run from reset.
        check_val("run_pc0", pc, 32'h0);
        free_step();
        check_val("run_pc1", pc, 32'h4);
        check_val("run_inst1", if_id_inst, 32'h0);
        check_val("run_valid1", {31'd0, if_id_valid}, 32'h1);
        free_step();
        check_val("run_pc2", pc, 32'h8);
        check_val("run_inst2", if_id_inst, 32'h1400_0801);
        free_step();
        check_val("run_pc3", pc, 32'hC);
        check_val("run_inst3", if_id_inst, 32'h1400_0022);
        check_val("run_cnt3", fetch_count, 32'd3);

        // Two stall cycles at pc=12.
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            check_val("stall_pc", pc, 32'hC);
            check_val("stall_inst", if_id_inst, 32'h1400_0022);
            check_val("stall_cnt", fetch_count, 32'd3);
        end
        free_step();
        check_val("resume_pc", pc, 32'h10);
        check_val("resume_inst", if_id_inst, 32'h0010_0c41);

        // Taken branch with misaligned target.
        step(1'b0, 1'b1, 32'h0000_001B, 1'b0, 32'h0);
        check_val("br_pc", pc, 32'h18);
        check_val("br_valid", {31'd0, if_id_valid}, 32'h0);
        check_val("br_inst", if_id_inst, 32'h0);
        free_step();
        check_val("br_tgt_inst", if_id_inst, 32'h0010_0c80);
        check_val("br_tgt_ipc", if_id_pc, 32'h18);

        // Stall, jump and branch together: branch wins, bubble despite stall.
        step(1'b1, 1'b1, 32'h4, 1'b1, 32'h20);
        check_val("prio_pc", pc, 32'h4);
        check_val("prio_valid", {31'd0, if_id_valid}, 32'h0);
        check_val("prio_inst", if_id_inst, 32'h0);

        // Jump to 0x1C, then asynchronous reset mid-cycle with a redirect pending.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1C);
        check_val("j1c_pc", pc, 32'h1C);
        check_val("j1c_cnt", fetch_count, 32'd5);
        #2;
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
        rst_n = 1'b0;
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1;
        check_reset_vals("arst_hold");
        @(negedge clk);
        stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        rst_n = 1'b1;
        model_reset();
        free_step();
        check_val("restart_pc", pc, 32'h4);
        check_val("restart_cnt", fetch_count, 32'd1);

        // Wrap at the top of the address space.
        step(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        check_val("top_pc", pc, 32'hFFFF_FFFC);
        free_step();
        check_val("wrap_pc", pc, 32'h0);
        check_val("wrap_ipc4", if_id_pc4, 32'h0);
        check_val("wrap_inst", if_id_inst, 32'hA500_003F);

        // Randomised mix of stalls and redirects.
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom,
                 $urandom_range(0, 5) == 0, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
